// File: rtl/ext_pipe_unit.sv
// Registered extension stage between decode and execute: extends/shifts an input field
// by mode and buffers results with tag and error flag in an in-order circular FIFO.
module ext_pipe_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 4,
    parameter int DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [IN_W-1:0]                in_data,
    input  logic [2:0]                     in_mode,
    input  logic [TAG_W-1:0]               in_tag,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [OUT_W-1:0]               out_data,
    output logic [TAG_W-1:0]               out_tag,
    output logic                           out_err,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        MODE_ZEXT   = 3'b000,
        MODE_SEXT   = 3'b001,
        MODE_UPPER  = 3'b010,
        MODE_BRANCH = 3'b011,
        MODE_BZEXT  = 3'b100,
        MODE_BSEXT  = 3'b101
    } mode_e;

    logic [OUT_W-1:0] mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic             mem_err  [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [OUT_W-1:0] res, sext;
    logic             res_err;
    logic             push, pop;

    // Handshake depends only on the registered count, never on out_ready.
    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_data = mem_data[rd_ptr];
    assign out_tag  = mem_tag[rd_ptr];
    assign out_err  = mem_err[rd_ptr];

    assign sext = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

    always_comb begin
        // NOTE: defaults first so every path assigns res/res_err and no latch is inferred.
        res     = '0;
        res_err = 1'b0;
        case (mode_e'(in_mode))
            MODE_ZEXT:   res = {{(OUT_W-IN_W){1'b0}}, in_data};
            MODE_SEXT:   res = sext;
            MODE_UPPER:  res = {in_data, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: res = sext << 2;
            MODE_BZEXT:  res = {{(OUT_W-8){1'b0}}, in_data[7:0]};
            MODE_BSEXT:  res = {{(OUT_W-8){in_data[7]}}, in_data[7:0]};
            default:     res_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            // NOTE: the storage is reset because the head-entry outputs must read 0 out of reset;
            // this is cheap only because DEPTH is small.
            for (int i = 0; i < DEPTH; i++) begin
                mem_data[i] <= '0;
                mem_tag[i]  <= '0;
                mem_err[i]  <= 1'b0;
            end
        end else if (flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= res;
                mem_tag[wr_ptr]  <= in_tag;
                mem_err[wr_ptr]  <= res_err;
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: tb/tb_ext_pipe_unit.sv
// Directed bench for ext_pipe_unit with a scoreboard queue of expected head entries.
module tb_ext_pipe_unit;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        err;
    } exp_t;

    logic        clk, rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [15:0] in_data;
    logic [2:0]  in_mode;
    logic [3:0]  in_tag, out_tag;
    logic [31:0] out_data;
    logic [1:0]  count;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t pend;

    logic [2:0]  mt_mode [6] = '{3'b001, 3'b000, 3'b010, 3'b011, 3'b101, 3'b100};
    logic [15:0] mt_data [6] = '{16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h0080, 16'h1280};
    logic [31:0] mt_exp  [6] = '{32'hFFFF8000, 32'h00008000, 32'h12340000,
                                 32'hFFFFFFFC, 32'hFFFFFF80, 32'h00000080};

    ext_pipe_unit #(.IN_W(16), .OUT_W(32), .TAG_W(4), .DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_tag(out_tag), .out_err(out_err), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", name, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] m, input logic [15:0] d);
        case (m)
            3'd0:    return {16'h0000, d};
            3'd1:    return 32'($signed(d));
            3'd2:    return {d, 16'h0000};
            3'd3:    return 32'($signed(d)) << 2;
            3'd4:    return {24'h0, d[7:0]};
            3'd5:    return 32'($signed(d[7:0]));
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive(input logic [2:0] m, input logic [15:0] d, input logic [3:0] t,
                         input logic [31:0] ed, input logic ee);
        in_valid = 1'b1;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
        pend     = '{data: ed, tag: t, err: ee};
    endtask

    // Samples at the falling edge, then returns 1 time unit after the next rising edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (out_valid && out_ready) begin
            chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", out_data, e.data);
                chk("out_tag", 32'(out_tag), 32'(e.tag));
                chk("out_err", 32'(out_err), 32'(e.err));
            end
        end
        if (flush) sb.delete();
        else if (in_valid && in_ready) sb.push_back(pend);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 20) begin
            cycle();
            n++;
        end
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_data = '0; in_mode = '0; in_tag = '0;
        pend = '0;

        // Reset state
        @(posedge clk); #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_tag", 32'(out_tag), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // Each legal mode, one beat, result visible one cycle after push
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(mt_mode[i], mt_data[i], 4'(i), mt_exp[i], 1'b0);
            cycle();
            in_valid = 1'b0;
            chk("mode_latency_valid", 32'(out_valid), 32'd1);
            cycle();
        end

        // Reserved mode
        drive(3'b110, 16'hABCD, 4'd5, 32'h0, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        drain();

        // Backpressure fills the FIFO, then drains in order
        out_ready = 1'b0;
        drive(3'b000, 16'h0011, 4'd1, 32'h00000011, 1'b0);
        cycle();
        drive(3'b000, 16'h0022, 4'd2, 32'h00000022, 1'b0);
        cycle();
        drive(3'b000, 16'h0033, 4'd3, 32'h00000033, 1'b0);
        chk("bp_in_ready_full", 32'(in_ready), 32'd0);
        chk("bp_count_full", 32'(count), 32'd2);
        out_ready = 1'b1;
        #1;
        chk("bp_no_comb_ready", 32'(in_ready), 32'd0);
        cycle();
        in_valid = 1'b0;
        chk("bp_ready_after_pop", 32'(in_ready), 32'd1);
        chk("bp_count_after_pop", 32'(count), 32'd1);
        cycle();
        drain();

        // Streaming, 16 back-to-back beats through a 2-entry FIFO
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            logic [2:0]  m;
            logic [15:0] d;
            m = 3'(i % 8);
            d = 16'($urandom);
            drive(m, d, 4'(i), model(m, d), m[2] & m[1]);
            cycle();
            chk("stream_count_le1", 32'(count <= 2'd1), 32'd1);
            chk("stream_valid", 32'(out_valid), 32'd1);
        end
        drain();

        // Flush with a held entry plus a simultaneous push and pop
        out_ready = 1'b0;
        drive(3'b001, 16'h0077, 4'd7, 32'h00000077, 1'b0);
        cycle();
        chk("flush_pre_count", 32'(count), 32'd1);
        drive(3'b000, 16'h0088, 4'd8, 32'h00000088, 1'b0);
        flush = 1'b1;
        out_ready = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("flush_no_ghost", 32'(out_valid), 32'd0);
        end

        // Asynchronous reset mid-burst with two entries held
        out_ready = 1'b0;
        drive(3'b000, 16'h00A1, 4'd10, 32'h000000A1, 1'b0);
        cycle();
        drive(3'b000, 16'h00A2, 4'd11, 32'h000000A2, 1'b0);
        cycle();
        in_valid = 1'b0;
        chk("midrst_pre_count", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        sb.delete();
        #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        drive(3'b100, 16'h12C3, 4'd12, 32'h000000C3, 1'b0);
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
